// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite types: response codes and the read-arbiter FSM states.
package axi4lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10
    } rd_arb_state_t;

endpackage

// File: rtl/axi4lite_rd_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after last_gnt, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_any
);

    logic [IDX_W-1:0] idx;

    // Scan from the farthest offset down so the nearest requester after last_gnt wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IDX_W'((int'(last_gnt) + k) % NUM_REQ);
            if (req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/axi4lite_rd_arbiter.sv
// Round-robin sharing of one AXI4-Lite read master port, one transaction outstanding.
module axi4lite_rd_arbiter
    import axi4lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [1:0]                    rsp_resp,
    output logic                          busy,
    output logic [ADDR_WIDTH-1:0]         ARADDR,
    output logic                          ARVALID,
    input  logic                          ARREADY,
    input  logic                          RVALID,
    input  logic [DATA_WIDTH-1:0]         RDATA,
    input  logic [1:0]                    RRESP,
    output logic                          RREADY
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    rd_arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]      gnt_q, last_gnt_q, pick_idx;
    logic                  pick_any;
    logic                  latch_req, ar_hs, r_hs;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    axi_resp_t             rsp_resp_q;
    logic [NUM_REQ-1:0]    rsp_valid_q, gnt_oh;
    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
        assign addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req      (req_valid),
        .last_gnt (last_gnt_q),
        .gnt_idx  (pick_idx),
        .gnt_any  (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        latch_req = 1'b0;
        ar_hs     = 1'b0;
        r_hs      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    latch_req = 1'b1;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (ARREADY) begin
                    ar_hs   = 1'b1;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (RVALID) begin
                    r_hs    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            last_gnt_q  <= IDX_W'(NUM_REQ - 1);
            araddr_q    <= '0;
            rsp_data_q  <= '0;
            rsp_resp_q  <= OKAY;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= '0;
            if (latch_req) begin
                gnt_q    <= pick_idx;
                araddr_q <= addr_arr[pick_idx];
            end
            // RRESP is forwarded verbatim, error codes included.
            if (r_hs) begin
                rsp_data_q  <= RDATA;
                rsp_resp_q  <= axi_resp_t'(RRESP);
                rsp_valid_q <= gnt_oh;
                last_gnt_q  <= gnt_q;
            end
        end
    end

    assign gnt_oh    = NUM_REQ'(1) << gnt_q;
    assign req_ready = ar_hs ? gnt_oh : '0;
    assign ARVALID   = (state_q == ADDR);
    assign RREADY    = (state_q == DATA);
    assign busy      = (state_q != IDLE);
    assign ARADDR    = araddr_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_resp  = rsp_resp_q;
    assign rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_axi4lite_rd_arbiter.sv
// Table-driven directed bench for axi4lite_rd_arbiter with hand-written reset sequences.
module tb_axi4lite_rd_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR-1:0] req_ready, rsp_valid;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_resp;
    logic          busy;
    logic [AW-1:0] ARADDR;
    logic          ARVALID, ARREADY, RVALID, RREADY;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;

    axi4lite_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_resp(rsp_resp), .busy(busy), .ARADDR(ARADDR), .ARVALID(ARVALID),
        .ARREADY(ARREADY), .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP),
        .RREADY(RREADY)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NR-1:0] rv;
        logic          ar;
        logic          r;
        logic [DW-1:0] rdata;
        logic [1:0]    rresp;
        logic          e_arv;
        logic          e_rr;
        logic          e_busy;
        logic [NR-1:0] e_rdy;
        logic [NR-1:0] e_rsv;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        logic [1:0]    e_resp;
    } vec_t;

    vec_t vec[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic vec_t mk(input logic [NR-1:0] rv, input logic ar, input logic r,
                                input logic [DW-1:0] rdata, input logic [1:0] rresp,
                                input logic e_arv, input logic e_rr, input logic e_busy,
                                input logic [NR-1:0] e_rdy, input logic [NR-1:0] e_rsv,
                                input logic [AW-1:0] e_addr, input logic [DW-1:0] e_data,
                                input logic [1:0] e_resp);
        vec_t v;
        v.rv = rv; v.ar = ar; v.r = r; v.rdata = rdata; v.rresp = rresp;
        v.e_arv = e_arv; v.e_rr = e_rr; v.e_busy = e_busy; v.e_rdy = e_rdy;
        v.e_rsv = e_rsv; v.e_addr = e_addr; v.e_data = e_data; v.e_resp = e_resp;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic check_outs(input string tag, input logic arv, input logic rr, input logic bsy,
                              input logic [NR-1:0] rdy, input logic [NR-1:0] rsv,
                              input logic [AW-1:0] addr, input logic [DW-1:0] data,
                              input logic [1:0] resp);
        check({tag, ".arvalid"},   32'(ARVALID),   32'(arv));
        check({tag, ".rready"},    32'(RREADY),    32'(rr));
        check({tag, ".busy"},      32'(busy),      32'(bsy));
        check({tag, ".req_ready"}, 32'(req_ready), 32'(rdy));
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(rsv));
        check({tag, ".araddr"},    ARADDR,         addr);
        check({tag, ".rsp_data"},  rsp_data,       data);
        check({tag, ".rsp_resp"},  32'(rsp_resp),  32'(resp));
    endtask

    task automatic run_vec(input string tag);
        for (int i = 0; i < vec.size(); i++) begin
            @(negedge clk);
            req_valid = vec[i].rv;
            ARREADY   = vec[i].ar;
            RVALID    = vec[i].r;
            RDATA     = vec[i].rdata;
            RRESP     = vec[i].rresp;
            #1;
            check_outs($sformatf("%s[%0d]", tag, i), vec[i].e_arv, vec[i].e_rr, vec[i].e_busy,
                       vec[i].e_rdy, vec[i].e_rsv, vec[i].e_addr, vec[i].e_data, vec[i].e_resp);
        end
        vec.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0; ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = '0;
        repeat (2) @(negedge clk);
        #1;
        check_outs("reset", 0, 0, 0, 4'h0, 4'h0, 32'h0, 32'h0, 2'b00);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        req_addr[i*AW +: AW] = a;
    endtask

    initial begin
        rst = 1'b0;
        req_valid = '0; req_addr = '0; ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = '0;
        set_addr(0, 32'h10); set_addr(1, 32'h20); set_addr(2, 32'h30); set_addr(3, 32'h40);
        do_reset();

        // Fairness with all requesters valid; slave always ready; RVALID held high
        // so it also fires spuriously in IDLE/ADDR. Requester 2 gets SLVERR/DEADBEEF.
        vec.push_back(mk(4'hF,1,1,32'h5555_5555,2'b11, 0,0,0,4'h0,4'h0,32'h00,32'h0,        2'b00));
        vec.push_back(mk(4'hF,1,1,32'h5555_5555,2'b11, 1,0,1,4'h1,4'h0,32'h10,32'h0,        2'b00));
        vec.push_back(mk(4'hF,1,1,32'hA000_0000,2'b00, 0,1,1,4'h0,4'h0,32'h10,32'h0,        2'b00));
        vec.push_back(mk(4'hF,1,1,32'h5555_5555,2'b11, 0,0,0,4'h0,4'h1,32'h10,32'hA000_0000,2'b00));
        vec.push_back(mk(4'hF,1,1,32'h5555_5555,2'b11, 1,0,1,4'h2,4'h0,32'h20,32'hA000_0000,2'b00));
        vec.push_back(mk(4'hF,1,1,32'hA000_0001,2'b01, 0,1,1,4'h0,4'h0,32'h20,32'hA000_0000,2'b00));
        vec.push_back(mk(4'hF,1,1,32'h5555_5555,2'b11, 0,0,0,4'h0,4'h2,32'h20,32'hA000_0001,2'b01));
        vec.push_back(mk(4'hF,1,1,32'h5555_5555,2'b11, 1,0,1,4'h4,4'h0,32'h30,32'hA000_0001,2'b01));
        vec.push_back(mk(4'hF,1,1,32'hDEAD_BEEF,2'b10, 0,1,1,4'h0,4'h0,32'h30,32'hA000_0001,2'b01));
        vec.push_back(mk(4'hF,1,1,32'h5555_5555,2'b11, 0,0,0,4'h0,4'h4,32'h30,32'hDEAD_BEEF,2'b10));
        vec.push_back(mk(4'hF,1,1,32'h5555_5555,2'b11, 1,0,1,4'h8,4'h0,32'h40,32'hDEAD_BEEF,2'b10));
        vec.push_back(mk(4'hF,1,1,32'hA000_0003,2'b11, 0,1,1,4'h0,4'h0,32'h40,32'hDEAD_BEEF,2'b10));
        vec.push_back(mk(4'hF,1,1,32'h5555_5555,2'b11, 0,0,0,4'h0,4'h8,32'h40,32'hA000_0003,2'b11));
        vec.push_back(mk(4'hF,1,1,32'h5555_5555,2'b11, 1,0,1,4'h1,4'h0,32'h10,32'hA000_0003,2'b11));
        vec.push_back(mk(4'hF,1,1,32'hA000_0004,2'b00, 0,1,1,4'h0,4'h0,32'h10,32'hA000_0003,2'b11));
        vec.push_back(mk(4'h0,0,0,32'h5555_5555,2'b11, 0,0,0,4'h0,4'h1,32'h10,32'hA000_0004,2'b00));
        run_vec("fair");

        // Single request from requester 0 with a 5-cycle AR stall and spurious R in IDLE/ADDR.
        set_addr(0, 32'h40);
        do_reset();
        vec.push_back(mk(4'h1,0,1,32'h5555_5555,2'b11, 0,0,0,4'h0,4'h0,32'h00,32'h0,        2'b00));
        vec.push_back(mk(4'h1,0,1,32'h5555_5555,2'b11, 1,0,1,4'h0,4'h0,32'h40,32'h0,        2'b00));
        for (int s = 0; s < 4; s++)
            vec.push_back(mk(4'h1,0,0,32'h0,2'b00, 1,0,1,4'h0,4'h0,32'h40,32'h0,2'b00));
        vec.push_back(mk(4'h1,1,0,32'h0,        2'b00, 1,0,1,4'h1,4'h0,32'h40,32'h0,        2'b00));
        vec.push_back(mk(4'h0,0,0,32'h0,        2'b00, 0,1,1,4'h0,4'h0,32'h40,32'h0,        2'b00));
        vec.push_back(mk(4'h0,0,1,32'h1000_0000,2'b00, 0,1,1,4'h0,4'h0,32'h40,32'h0,        2'b00));
        vec.push_back(mk(4'h0,0,0,32'h0,        2'b00, 0,0,0,4'h0,4'h1,32'h40,32'h1000_0000,2'b00));
        vec.push_back(mk(4'h0,0,0,32'h0,        2'b00, 0,0,0,4'h0,4'h0,32'h40,32'h1000_0000,2'b00));
        run_vec("single");

        // Requester 1 reaches DATA, then reset strikes between clock edges.
        vec.push_back(mk(4'h2,1,0,32'h0,2'b00, 0,0,0,4'h0,4'h0,32'h40,32'h1000_0000,2'b00));
        vec.push_back(mk(4'h2,1,0,32'h0,2'b00, 1,0,1,4'h2,4'h0,32'h20,32'h1000_0000,2'b00));
        vec.push_back(mk(4'h0,0,0,32'h0,2'b00, 0,1,1,4'h0,4'h0,32'h20,32'h1000_0000,2'b00));
        run_vec("mid");
        #2;
        rst = 1'b0;
        #1;
        check_outs("rst_async", 0, 0, 0, 4'h0, 4'h0, 32'h0, 32'h0, 2'b00);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        req_valid = 4'hF; ARREADY = 1'b1; RVALID = 1'b0;
        #1;
        check_outs("rst_rel", 0, 0, 0, 4'h0, 4'h0, 32'h0, 32'h0, 2'b00);
        @(negedge clk);
        #1;
        check_outs("rst_gnt0", 1, 0, 1, 4'h1, 4'h0, 32'h40, 32'h0, 2'b00);
        @(negedge clk);
        req_valid = 4'h0; RVALID = 1'b1; RDATA = 32'h0BAD_F00D; RRESP = 2'b11;
        #1;
        check_outs("rst_data", 0, 1, 1, 4'h0, 4'h0, 32'h40, 32'h0, 2'b00);
        @(negedge clk);
        RVALID = 1'b0;
        #1;
        check_outs("rst_rsp", 0, 0, 0, 4'h0, 4'h1, 32'h40, 32'h0BAD_F00D, 2'b11);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/axi4lite_rd_arbiter.md
# axi4lite_rd_arbiter

Round-robin arbiter and sequencer that shares one AXI4-Lite read-only master port (AR and R channels) between `NUM_REQ` internal requesters. It accepts one read request at a time, drives the AR handshake, waits for the R beat, and routes the returned data and response to the granted requester. It sits between client logic and the AXI4-Lite read slave, with exactly one transaction outstanding.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: AXI address width.
- `DATA_WIDTH`, 32: AXI data width.
- `NUM_REQ`, 4: number of requesters; legal range 2..16.

Ports:
- Clock and reset: single clock `clk`; reset `rst` is asynchronous and active-low.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-low reset.
- `req_valid`  in  NUM_REQ  per-requester read request.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_ready`  out  NUM_REQ  one-hot, one cycle; the request was accepted on AR.
- `rsp_valid`  out  NUM_REQ  one-hot, one cycle; response delivered to the requester.
- `rsp_data`  out  DATA_WIDTH  read data, shared by all requesters.
- `rsp_resp`  out  2  read response, shared by all requesters.
- `busy`  out  1  high when not IDLE.
- `ARADDR`  out  ADDR_WIDTH  AXI read address.
- `ARVALID`  out  1  AXI read address valid.
- `ARREADY`  in  1  AXI read address ready.
- `RVALID`  in  1  AXI read data valid.
- `RDATA`  in  DATA_WIDTH  AXI read data.
- `RRESP`  in  2  AXI read response.
- `RREADY`  out  1  AXI read data ready.

## Operation
- FSM states are IDLE, ADDR and DATA.
- **IDLE**
  - If any `req_valid` bit is set, select a winner by round-robin.
  - The search starts at `last_gnt+1` and wraps modulo `NUM_REQ`.
  - Latch the winner index into `gnt` and its address into `ARADDR`, then move to ADDR.
- **ADDR**
  - `ARVALID`=1; `ARADDR` is held stable.
  - On `ARVALID && ARREADY`: `req_ready[gnt]`=1 in that same cycle (combinational from state and `ARREADY`), then move to DATA.
- **DATA**
  - `RREADY`=1.
  - On `RVALID && RREADY`: register `rsp_data`=`RDATA`, `rsp_resp`=`RRESP`, `rsp_valid`=one-hot(`gnt`) for exactly one cycle.
  - Set `last_gnt`=`gnt` and return to IDLE.
- `ARVALID`, `RREADY` and `busy` are decoded from the registered state only (no input-to-output paths), except `req_ready`.
- The block does not decode `RRESP`; it passes any value through unchanged (OKAY, SLVERR, DECERR).
- Requester contract:
  - Hold `req_valid` and `req_addr` until `req_ready`.
  - Deasserting `req_valid` before being latched in IDLE is allowed.
  - Once latched, the transaction completes regardless of later `req_valid`.
- `rsp_valid` has no backpressure; requesters must sink the response in its cycle.

## Timing
- Reset values: `ARVALID`=0, `RREADY`=0, `ARADDR`=0, `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_resp`=2'b00, `busy`=0.
- Also at reset: state=IDLE, `last_gnt`=NUM_REQ-1, so requester 0 wins first.
- Latency, with `req_valid` seen in IDLE at edge N:
  - `ARVALID` high from cycle N+1.
  - With `ARREADY` and `RVALID` immediate, the R handshake occurs in cycle N+2 and `rsp_valid` is high in cycle N+3.
  - Minimum: one transaction per 3 cycles.
- IDLE may arbitrate in the same cycle that `rsp_valid` is high; back-to-back transactions have no bubble beyond the IDLE cycle.
- Boundary conditions:
  - **`ARREADY` low for any number of cycles:** `ARVALID` and `ARADDR` stay constant, with no timeout.
  - **`RVALID` while in IDLE or ADDR:** protocol violation by the slave; ignored, with no `rsp_valid` and no state change.
  - **All requesters continuously valid:** grants rotate strictly 0,1,…,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transactions.
  - **Reset asserted mid-transaction (ADDR or DATA):** all outputs reach reset values asynchronously; the in-flight transaction is abandoned and no `rsp_valid` is issued.
  - **Reset deassertion:** takes effect synchronously at the next `clk` edge (release is synchronized externally).

## Structure
- Shared package `axi4lite_pkg`:
  - `axi_resp_t` codes: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - FSM typedef `rd_arb_state_t` (IDLE, ADDR, DATA).
- One sub-module, `rr_pick`: a combinational round-robin selector.
  - Inputs: `req` and `last_gnt`.
  - Outputs: `gnt_idx` and `gnt_any`.
  - Parameter: `NUM_REQ`.
- The top level holds the FSM, address/index latches and response registers.

## Test plan
- **Single request:** `req_valid`=4'b0001, `req_addr[0]`=32'h0000_0040; slave gives `ARREADY` in the first ARVALID cycle and returns `RDATA`=32'h1000_0000, `RRESP`=00. Expect `ARADDR`=32'h0000_0040, one `req_ready[0]` pulse, then `rsp_valid`=4'b0001 for one cycle with `rsp_data`=32'h1000_0000 and `rsp_resp`=00.
- **Fairness:** all four requesters valid continuously with distinct addresses 0x10/0x20/0x30/0x40. Expect `ARADDR` order 0x10, 0x20, 0x30, 0x40, 0x10, and never more than one AR before the matching R.
- **AR stall:** `ARREADY` held low for 5 cycles. Expect `ARVALID`=1 and `ARADDR` stable for all 6 cycles; `req_ready` stays low until the handshake cycle.
- **Error pass-through:** `RRESP`=2'b10 with `RDATA`=32'hDEAD_BEEF. Expect `rsp_resp`=2'b10 and `rsp_data`=32'hDEAD_BEEF delivered to the granted requester only.
- **Spurious R:** `RVALID` pulsed while in IDLE and while in ADDR. Expect no `rsp_valid` and no state change; the later proper R completes normally.
- **Reset mid-flight:** `rst` driven low during DATA, between clock edges. Expect `ARVALID`, `RREADY`, `busy` and `rsp_valid` at 0 before the next edge; after release, the first grant goes to requester 0.
